// File: rtl/simd_add_pkg.sv
// simd_add_pkg: shared lane geometry, FSM states and timeout default for the SIMD add packer
package simd_add_pkg;
  localparam int LANES = 4;
  localparam int LANE_W = 12;
  localparam int FLUSH_TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {FILL, ADD, DRAIN} state_t;
endpackage

// File: rtl/_simd_add_4.sv
// _simd_add_4: four independent 12-bit lane adders, carries never cross lanes
module _simd_add_4
  import simd_add_pkg::*;
(
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  output logic [LANES*LANE_W-1:0] sum,
  output logic                    ap_ready
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sum[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W];
  end
  assign ap_ready = 1'b1;
endmodule

// File: rtl/simd_add4_packer.sv
// simd_add4_packer: gathers up to four operand pairs, adds them in one packed cycle, drains lane sums
module simd_add4_packer
  import simd_add_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_a,
  input  logic [LANE_W-1:0] in_b,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_sum,
  output logic [1:0]        out_lane,
  output logic              out_last
);
  localparam int IW = $clog2(FLUSH_TIMEOUT + 1);
  state_t state;
  logic [2:0] cnt, n;
  logic [1:0] idx;
  logic [IW-1:0] idle;
  logic [LANE_W-1:0] sa [LANES];
  logic [LANE_W-1:0] sb [LANES];
  logic [LANE_W-1:0] res [LANES];
  logic [LANES*LANE_W-1:0] pa, pb, ps;
  logic accept;
  assign in_ready = state == FILL;
  assign accept = in_valid && in_ready;
  assign out_valid = state == DRAIN;
  assign out_sum = res[idx];
  assign out_lane = idx;
  assign out_last = {1'b0, idx} == n - 3'd1;
  // slots beyond the group size may hold stale data from an earlier group
  always_comb begin
    pa = '0;
    pb = '0;
    for (int i = 0; i < LANES; i++) begin
      pa[i*LANE_W +: LANE_W] = (i < int'(cnt)) ? sa[i] : '0;
      pb[i*LANE_W +: LANE_W] = (i < int'(cnt)) ? sb[i] : '0;
    end
  end
  _simd_add_4 u_add (
    .a       (pa),
    .b       (pb),
    .sum     (ps),
    .ap_ready()
  );
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= FILL;
      cnt <= '0;
      n <= '0;
      idx <= '0;
      idle <= '0;
      for (int i = 0; i < LANES; i++) begin
        sa[i] <= '0;
        sb[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            sa[cnt[1:0]] <= in_a;
            sb[cnt[1:0]] <= in_b;
            cnt <= cnt + 3'd1;
            idle <= '0;
            if (cnt == 3'd3 || in_flush) state <= ADD;
          end else if (cnt != 3'd0) begin
            if (idle == IW'(FLUSH_TIMEOUT)) begin
              state <= ADD;
              idle <= '0;
            end else idle <= idle + 1'b1;
          end
        end
        ADD: begin
          for (int i = 0; i < LANES; i++) res[i] <= ps[i*LANE_W +: LANE_W];
          n <= cnt;
          idx <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              cnt <= '0;
              idx <= '0;
              state <= FILL;
            end else idx <= idx + 2'd1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_simd_add4_packer.sv
// tb_simd_add4_packer: scoreboard bench with a group-level reference model of the packer
module tb_simd_add4_packer;
  import simd_add_pkg::*;
  localparam int TO = 16;
  logic ap_clk = 0, ap_rst_n = 0, in_valid = 0, in_flush = 0, out_ready = 1;
  logic [11:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, out_last;
  logic [11:0] out_sum;
  logic [1:0] out_lane;
  typedef struct packed {logic [11:0] sum; logic [1:0] lane; logic last;} res_t;
  res_t sbq[$];
  res_t held, exp_r;
  logic stall = 0;
  logic [11:0] ga[$], gb[$];
  int checks = 0, errors = 0, rdy_mode = 0;

  simd_add4_packer #(.FLUSH_TIMEOUT(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_flush(in_flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_lane(out_lane), .out_last(out_last)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a closed group yields one result per beat, sums wrap at 4096
  function automatic void close_group();
    res_t r;
    for (int i = 0; i < ga.size(); i++) begin
      r.sum = 12'((int'(ga[i]) + int'(gb[i])) % 4096);
      r.lane = 2'(i);
      r.last = (i == ga.size() - 1);
      sbq.push_back(r);
    end
    ga.delete();
    gb.delete();
  endfunction

  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", out_sum, held.sum);
        chk("hold_lane", out_lane, held.lane);
        chk("hold_last", out_last, held.last);
      end
      if (out_valid) chk("in_ready_busy", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result lane %0d sum %0d expected none at %0t", out_lane, out_sum, $time);
        end else begin
          exp_r = sbq.pop_front();
          chk("sum", out_sum, exp_r.sum);
          chk("lane", out_lane, exp_r.lane);
          chk("last", out_last, exp_r.last);
        end
      end
      stall = out_valid && !out_ready;
      held = '{out_sum, out_lane, out_last};
    end else stall = 0;
  end

  initial forever begin
    @(posedge ap_clk);
    #1;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic fl);
    int t = 0;
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_flush = fl;
    @(negedge ap_clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge ap_clk);
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge ap_clk);
    #1;
    in_valid = 0;
    in_flush = 0;
    ga.push_back(a);
    gb.push_back(b);
    if (fl || ga.size() == 4) close_group();
  endtask

  task automatic wait_empty();
    int t = 0;
    while (sbq.size() != 0 && t < 300) begin
      t++;
      @(negedge ap_clk);
    end
    chk("drain_done", sbq.size(), 0);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_lane(input int lane);
    int t = 0;
    @(negedge ap_clk);
    while (!(out_valid && out_lane == 2'(lane)) && t < 100) begin
      t++;
      @(negedge ap_clk);
    end
    chk("wait_lane", int'(out_valid && out_lane == 2'(lane)), 1);
  endtask

  initial begin
    #7;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_out_last", out_last, 0);
    #5 ap_rst_n = 1;
    @(posedge ap_clk);
    #1;
    send(12'd1, 12'd2, 0);
    send(12'd3, 12'd4, 0);
    send(12'hFFF, 12'd1, 0);
    send(12'h800, 12'h800, 0);
    @(negedge ap_clk);
    chk("lat_add_valid", out_valid, 0);
    chk("lat_add_in_ready", in_ready, 0);
    @(negedge ap_clk);
    chk("lat_drain_valid", out_valid, 1);
    wait_empty();
    send(12'd5, 12'd6, 0);
    send(12'd7, 12'd8, 1);
    wait_empty();
    send(12'd10, 12'd20, 0);
    repeat (TO) begin
      @(negedge ap_clk);
      chk("no_early_timeout", out_valid, 0);
    end
    close_group();
    wait_empty();
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 0);
    wait_lane(0);
    repeat (5) @(posedge ap_clk);
    #1;
    rdy_mode = 0;
    wait_empty();
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, 3) == 0 ? 12'hFFF : 12'($urandom_range(0, 4095)),
           12'($urandom_range(0, 4095)), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(posedge ap_clk);
      #1;
    end
    if (ga.size() != 0) send(12'd1, 12'd1, 1);
    rdy_mode = 0;
    wait_empty();
    for (int i = 0; i < 4; i++) send(12'(100 + i), 12'd1, 0);
    wait_lane(1);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 0;
    sbq.delete();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_lane", out_lane, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1;
    repeat (10) begin
      @(negedge ap_clk);
      chk("post_rst_idle", out_valid, 0);
    end
    @(posedge ap_clk);
    #1;
    send(12'd40, 12'd2, 1);
    wait_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/simd_add4_packer.md
SIMD_ADD4_PACKER -- requirements
Module: simd_add4_packer

Interface
REQ-001 SHALL have parameter FLUSH_TIMEOUT, default 16, meaning idle cycles in FILL with a partial group before it is issued automatically.
REQ-002 SHALL have port ap_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port ap_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair present.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 SHALL have port in_a  input  12  addend A.
REQ-007 SHALL have port in_b  input  12  addend B.
REQ-008 SHALL have port in_flush  input  1  qualified by in_valid; closes the group after this beat.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_sum  output  12  lane sum.
REQ-012 SHALL have port out_lane  output  2  lane index of out_sum, 0..3.
REQ-013 SHALL have port out_last  output  1  final result of the current group.

Function
REQ-014 SHALL implement three states, FILL, ADD and DRAIN, with FILL as the reset state.
REQ-015 SHALL drive in_ready=1 exactly when state==FILL, with no combinational dependence on in_valid.
REQ-016 SHALL store each beat accepted in FILL (in_valid&in_ready) into lane slot cnt and then increment cnt.
REQ-017 SHALL go FILL->ADD when an accepted beat makes cnt=4, or an accepted beat has in_flush=1, or the idle counter reaches FLUSH_TIMEOUT while cnt>0.
REQ-018 SHALL clear the idle counter on every accepted beat and on leaving FILL, and increment it only in FILL with cnt>0 and no accept.
REQ-019 SHALL ignore in_flush when in_valid=0, and SHALL never leave FILL while cnt=0.
REQ-020 SHALL, in ADD, feed all four lanes to the packed adder in a single cycle, with unused lanes' operands forced to 0.
REQ-021 SHALL, in ADD, register all four sums, latch group size n=cnt, and go to DRAIN on the next edge.
REQ-022 SHALL compute each lane sum modulo 2^12 with the carry discarded (0xFFF+0x001=0x000), and SHALL never propagate a carry between lanes.
REQ-023 SHALL, in DRAIN, assert out_valid=1 with out_sum=res[idx], out_lane=idx and out_last=(idx==n-1), starting from idx=0.
REQ-024 SHALL hold out_sum, out_lane and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL advance idx on out_valid&out_ready, and SHALL on the last result clear cnt and idx and return to FILL.
REQ-026 SHALL have a latency such that a closing beat accepted at edge T gives ADD in cycle T+1 and out_valid=1 in cycle T+2.
REQ-027 SHALL allow at most one group in flight, with no input accepted during ADD or DRAIN.

Reset
REQ-028 SHALL, while ap_rst_n=0 and independent of ap_clk, force state=FILL, cnt=0, idx=0, the idle counter to 0 and all result registers to 0.
REQ-029 SHALL have reset output values in_ready=1, out_valid=0, out_sum=0, out_lane=0 and out_last=0.
REQ-030 SHALL discard any partial or drained group on reset mid-operation, with no result emitted for it after reset deasserts.

Structure
REQ-031 SHALL take LANES=4, LANE_W=12, the state enum and the FLUSH_TIMEOUT default from shared package simd_add_pkg.
REQ-032 SHALL perform lane addition only through one instance of the team's existing four12 SIMD adder module _simd_add_4, with its ap_ready left unconnected.
REQ-033 SHALL have combinational logic only between the operand slots and the adder, with sums registered at the adder output.

Verification
REQ-034 SHALL cover a full group: four beats (1,2),(3,4),(0xFFF,1),(0x800,0x800) back-to-back with out_ready=1 -> sums 3,7,0x000,0x000; lanes 0..3; out_last only on lane 3; first out_valid two cycles after the fourth accept.
REQ-035 SHALL cover flush: two beats (5,6) then (7,8) with in_flush=1 -> exactly two results, 11 and 15, with out_last on lane 1.
REQ-036 SHALL cover timeout: one beat (10,20) then in_valid=0 for 16 cycles -> single result 30 with out_last=1, and no result before the timeout.
REQ-037 SHALL cover backpressure: out_ready=0 for 5 cycles during DRAIN -> outputs stable, in_ready=0 throughout, no result lost or duplicated.
REQ-038 SHALL cover reset mid-DRAIN: ap_rst_n pulsed low after lane 1 is accepted -> out_valid=0 immediately, in_ready=1, and no stale lanes 2..3 after reset.
